// File: rtl/axi_rx_channel.sv
// ---------------------------------------------------------------------------
// axi_rx_channel
//
// Receiving end of an AXI-style VALID/READY channel. Drives a registered
// READY, captures xDATA on every handshake into a small first-word-fall-
// through buffer and presents the buffered words to a local consumer through
// its own rx_valid/rx_ready pair. Usable on any channel where this side is
// the sink (W/AW/AR at a slave, R/B at a master).
//
// Parameters:
//   WIDTH    payload width in bits
//   DEPTH    buffer entries, power of two, >= 2
//
// Ports:
//   ACLK      in   clock, rising edge
//   ARESETn   in   synchronous active-low reset
//   VALID     in   bus valid from the transmitter
//   READY     out  bus ready, registered (no path from VALID or rx_ready)
//   xDATA     in   bus payload
//   rx_data   out  head-of-buffer word (don't-care while rx_valid = 0)
//   rx_valid  out  head word present
//   rx_ready  in   consumer accepts the head word
//   rx_count  out  number of occupied entries
//   proto_err out  sticky protocol-violation flag
//
// Build option:
//   RX_PROTOCOL_CHECK_EN  when defined, a bus protocol checker drives
//                         proto_err (VALID dropped or xDATA changed while
//                         stalled). When undefined proto_err is tied to 0.
// ---------------------------------------------------------------------------
module axi_rx_channel #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       ACLK,
    input  logic                       ARESETn,
    input  logic                       VALID,
    output logic                       READY,
    input  logic [WIDTH-1:0]           xDATA,
    output logic [WIDTH-1:0]           rx_data,
    output logic                       rx_valid,
    input  logic                       rx_ready,
    output logic [$clog2(DEPTH+1)-1:0] rx_count,
    output logic                       proto_err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } rx_state_t;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    rx_state_t        state_r;
    logic             ready_r;
    logic             rx_valid_r;
    logic [WIDTH-1:0] rx_data_r;

    logic             push_s;
    logic             pop_s;
    logic [CNT_W-1:0] count_next_s;
    logic [PTR_W-1:0] rd_ptr_next_s;
    logic [WIDTH-1:0] head_next_s;
    rx_state_t        state_next_s;

    // Handshakes, next occupancy, next read pointer and next head word.
    always_comb begin
        push_s        = VALID && ready_r;
        pop_s         = rx_valid_r && rx_ready;
        count_next_s  = count_r;
        rd_ptr_next_s = rd_ptr_r;
        head_next_s   = mem_r[rd_ptr_r];

        if (push_s && !pop_s) begin
            count_next_s = count_r + CNT_ONE;
        end else if (!push_s && pop_s) begin
            count_next_s = count_r - CNT_ONE;
        end else begin
            count_next_s = count_r;
        end

        if (pop_s) begin
            rd_ptr_next_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_next_s = rd_ptr_r;
        end

        // A push can only land on the next head slot when the buffer is
        // otherwise drained, so the incoming word bypasses the memory.
        if (push_s && (wr_ptr_r == rd_ptr_next_s)) begin
            head_next_s = xDATA;
        end else begin
            head_next_s = mem_r[rd_ptr_next_s];
        end
    end

    // Occupancy state transitions.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (push_s) begin
                    state_next_s = ST_PARTIAL;
                end else begin
                    state_next_s = ST_EMPTY;
                end
            end
            ST_PARTIAL: begin
                if (push_s && !pop_s && (count_r == CNT_LAST)) begin
                    state_next_s = ST_FULL;
                end else if (pop_s && !push_s && (count_r == CNT_ONE)) begin
                    state_next_s = ST_EMPTY;
                end else begin
                    state_next_s = ST_PARTIAL;
                end
            end
            ST_FULL: begin
                if (pop_s) begin
                    state_next_s = ST_PARTIAL;
                end else begin
                    state_next_s = ST_FULL;
                end
            end
            default: begin
                state_next_s = ST_EMPTY;
            end
        endcase
    end

    // Control registers: pointers, count, state and the registered flags.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            state_r    <= ST_EMPTY;
            ready_r    <= 1'b0;
            rx_valid_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            rd_ptr_r   <= rd_ptr_next_s;
            count_r    <= count_next_s;
            state_r    <= state_next_s;
            ready_r    <= (count_next_s != CNT_FULL);
            rx_valid_r <= (state_next_s != ST_EMPTY);
        end
    end

    // Storage and registered head word; contents are intentionally not reset.
    always_ff @(posedge ACLK) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= xDATA;
        end
        rx_data_r <= head_next_s;
    end

    assign READY    = ready_r;
    assign rx_valid = rx_valid_r;
    assign rx_data  = rx_data_r;
    assign rx_count = count_r;

`ifdef RX_PROTOCOL_CHECK_EN
    logic             stall_r;
    logic [WIDTH-1:0] stall_data_r;
    logic             proto_err_r;

    // Remember a stalled transfer and flag it if it is withdrawn or altered.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            stall_r      <= 1'b0;
            stall_data_r <= '0;
            proto_err_r  <= 1'b0;
        end else begin
            stall_r      <= VALID && !ready_r;
            stall_data_r <= xDATA;
            if (stall_r && (!VALID || (xDATA != stall_data_r))) begin
                proto_err_r <= 1'b1;
            end
        end
    end

    assign proto_err = proto_err_r;
`else
    assign proto_err = 1'b0;
`endif

endmodule
